trace_line_arbiter: RTL and testbench

//  Shares one cpu_checker char port among N_SRC trace sources, granting the checker for one whole line
//  ('^' ... '#') at a time, round-robin. Streams the granted source's chars to the checker, samples the

---
 rtl/trace_line_arbiter.sv | 188 ++++++++++++++++++
 tb/tb_trace_line_arbiter.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/trace_line_arbiter.sv
// Round-robin arbiter that lends one cpu_checker char port to N_SRC trace sources, one whole
// '^'...'#' line at a time, and returns a tagged result (or abort) per line.
module trace_line_arbiter #(
  parameter int         N_SRC     = 4,
  parameter int         SRC_W     = 2,
  parameter int         MAX_LEN   = 64,
  parameter logic [7:0] IDLE_CHAR = 8'h00
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [N_SRC*8-1:0] req_char,
  input  logic [N_SRC-1:0]   req_valid,
  output logic [N_SRC-1:0]   req_ready,
  output logic [7:0]         chk_char,
  input  logic [1:0]         chk_format_type,
  input  logic [3:0]         chk_error_code,
  output logic               res_valid,
  output logic [SRC_W-1:0]   res_src,
  output logic [1:0]         res_format_type,
  output logic [3:0]         res_error_code,
  output logic               res_abort,
  output logic               busy,
  output logic [SRC_W-1:0]   grant_src
);

  localparam int               LEN_W    = $clog2(MAX_LEN + 1);
  localparam logic [7:0]       SOL_CHAR = 8'h5E;
  localparam logic [7:0]       EOL_CHAR = 8'h23;
  localparam logic [LEN_W-1:0] LEN_ONE  = LEN_W'(1);
  // A non-'#' char arriving with this count already in would leave no room for the '#'
  localparam logic [LEN_W-1:0] LEN_LAST = LEN_W'(MAX_LEN - 1);

  typedef enum logic [1:0] {IDLE, LOCK, DRAIN1, DRAIN2} state_t;

  state_t           state_r, state_next_s;
  logic [SRC_W-1:0] ptr_r, ptr_next_s;
  logic [SRC_W-1:0] grant_r, grant_next_s;
  logic [LEN_W-1:0] len_r, len_next_s;
  logic [7:0]       chk_char_r, chk_next_s;
  logic             res_valid_r, res_valid_next_s;
  logic             res_abort_r, res_abort_next_s;
  logic [SRC_W-1:0] res_src_r, res_src_next_s;
  logic [1:0]       res_fmt_r, res_fmt_next_s;
  logic [3:0]       res_err_r, res_err_next_s;
  logic [N_SRC-1:0] ready_s;
  logic [N_SRC-1:0] sol_hit_s;
  logic [7:0]       src_char_s [N_SRC];
  logic             found_s;
  logic [SRC_W-1:0] found_idx_s;
  logic             abort_s;
  logic [7:0]       cur_char_s;
  logic             cur_valid_s;

  function automatic logic [SRC_W-1:0] rr_index(input logic [SRC_W-1:0] base, input int offset);
    int sum;
    sum = int'(base) + offset;
    sum = (sum >= N_SRC) ? (sum - N_SRC) : sum;
    return SRC_W'(sum);
  endfunction

  // Per-source char slices and start-of-line detection
  always_comb begin
    for (int i = 0; i < N_SRC; i++) begin
      src_char_s[i] = req_char[i*8 +: 8];
      sol_hit_s[i]  = req_valid[i] && (req_char[i*8 +: 8] == SOL_CHAR);
    end
  end

  // Round-robin search from ptr upward; scanning offsets downward lets the smallest offset win
  always_comb begin
    found_s     = 1'b0;
    found_idx_s = '0;
    for (int k = N_SRC - 1; k >= 0; k--) begin
      found_idx_s = sol_hit_s[rr_index(ptr_r, k)] ? rr_index(ptr_r, k) : found_idx_s;
      found_s     = found_s | sol_hit_s[rr_index(ptr_r, k)];
    end
  end

  assign cur_char_s  = src_char_s[grant_r];
  assign cur_valid_s = req_valid[grant_r];

  // Next-state, handshake and result decode
  always_comb begin
    state_next_s     = state_r;
    ptr_next_s       = ptr_r;
    grant_next_s     = grant_r;
    len_next_s       = len_r;
    chk_next_s       = IDLE_CHAR;
    ready_s          = '0;
    abort_s          = 1'b0;
    res_valid_next_s = 1'b0;
    res_abort_next_s = res_abort_r;
    res_src_next_s   = res_src_r;
    res_fmt_next_s   = res_fmt_r;
    res_err_next_s   = res_err_r;
    case (state_r)
      IDLE: begin
        // Stray chars outside a line are accepted and thrown away
        for (int i = 0; i < N_SRC; i++) begin
          ready_s[i] = req_valid[i] && (src_char_s[i] != SOL_CHAR);
        end
        if (found_s) begin
          ready_s[found_idx_s] = 1'b1;
          chk_next_s           = SOL_CHAR;
          grant_next_s         = found_idx_s;
          len_next_s           = LEN_ONE;
          state_next_s         = LOCK;
        end else begin
          state_next_s = IDLE;
        end
      end
      LOCK: begin
        ready_s[grant_r] = 1'b1;
        abort_s = !cur_valid_s || ((cur_char_s != EOL_CHAR) && (len_r == LEN_LAST));
        if (abort_s) begin
          res_valid_next_s = 1'b1;
          res_abort_next_s = 1'b1;
          res_src_next_s   = grant_r;
          res_fmt_next_s   = 2'b00;
          res_err_next_s   = 4'b0000;
          ptr_next_s       = rr_index(grant_r, 1);
          state_next_s     = IDLE;
        end else if (cur_char_s == EOL_CHAR) begin
          chk_next_s   = EOL_CHAR;
          state_next_s = DRAIN1;
        end else begin
          chk_next_s   = cur_char_s;
          len_next_s   = (cur_char_s == SOL_CHAR) ? LEN_ONE : (len_r + LEN_ONE);
          state_next_s = LOCK;
        end
      end
      DRAIN1: begin
        state_next_s = DRAIN2;
      end
      DRAIN2: begin
        // Checker verdict for the '#' is only valid in this cycle
        res_valid_next_s = 1'b1;
        res_abort_next_s = 1'b0;
        res_src_next_s   = grant_r;
        res_fmt_next_s   = chk_format_type;
        res_err_next_s   = chk_error_code;
        ptr_next_s       = rr_index(grant_r, 1);
        state_next_s     = IDLE;
      end
      default: begin
        state_next_s = IDLE;
      end
    endcase
  end

  // State, pointer, forwarded char and result registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r     <= IDLE;
      ptr_r       <= '0;
      grant_r     <= '0;
      len_r       <= '0;
      chk_char_r  <= IDLE_CHAR;
      res_valid_r <= 1'b0;
      res_abort_r <= 1'b0;
      res_src_r   <= '0;
      res_fmt_r   <= 2'b00;
      res_err_r   <= 4'b0000;
    end else begin
      state_r     <= state_next_s;
      ptr_r       <= ptr_next_s;
      grant_r     <= grant_next_s;
      len_r       <= len_next_s;
      chk_char_r  <= chk_next_s;
      res_valid_r <= res_valid_next_s;
      res_abort_r <= res_abort_next_s;
      res_src_r   <= res_src_next_s;
      res_fmt_r   <= res_fmt_next_s;
      res_err_r   <= res_err_next_s;
    end
  end

  assign req_ready       = ready_s & {N_SRC{~reset}};
  assign chk_char        = chk_char_r;
  assign res_valid       = res_valid_r;
  assign res_abort       = res_abort_r;
  assign res_src         = res_src_r;
  assign res_format_type = res_fmt_r;
  assign res_error_code  = res_err_r;
  assign busy            = (state_r != IDLE);
  assign grant_src       = grant_r;

endmodule

// File: tb/tb_trace_line_arbiter.sv
// Bench for trace_line_arbiter: per-source line drivers, a line-level reference model of
// arbitration/forwarding/results, directed scenarios, random rounds and a short-MAX_LEN instance.
module tb_trace_line_arbiter;
  localparam int N    = 4;
  localparam int ML   = 64;
  localparam int ML_S = 8;

  logic           clk = 1'b0;
  logic           reset;
  logic [N*8-1:0] req_char;
  logic [N-1:0]   req_valid, req_ready;
  logic [7:0]     chk_char;
  logic [1:0]     chk_format_type;
  logic [3:0]     chk_error_code;
  logic           res_valid, res_abort, busy;
  logic [1:0]     res_src, res_format_type, grant_src;
  logic [3:0]     res_error_code;

  logic [N*8-1:0] s_req_char;
  logic [N-1:0]   s_req_valid, s_req_ready;
  logic [7:0]     s_chk_char;
  logic           s_res_valid, s_res_abort, s_busy;
  logic [1:0]     s_res_src, s_res_format_type, s_grant_src;
  logic [3:0]     s_res_error_code;

  trace_line_arbiter u_dut (
    .clk(clk), .reset(reset), .req_char(req_char), .req_valid(req_valid), .req_ready(req_ready),
    .chk_char(chk_char), .chk_format_type(chk_format_type), .chk_error_code(chk_error_code),
    .res_valid(res_valid), .res_src(res_src), .res_format_type(res_format_type),
    .res_error_code(res_error_code), .res_abort(res_abort), .busy(busy), .grant_src(grant_src));

  trace_line_arbiter #(.MAX_LEN(ML_S)) u_short (
    .clk(clk), .reset(reset), .req_char(s_req_char), .req_valid(s_req_valid), .req_ready(s_req_ready),
    .chk_char(s_chk_char), .chk_format_type(2'b00), .chk_error_code(4'b0000),
    .res_valid(s_res_valid), .res_src(s_res_src), .res_format_type(s_res_format_type),
    .res_error_code(s_res_error_code), .res_abort(s_res_abort), .busy(s_busy), .grant_src(s_grant_src));

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // source drivers
  string    ln  [N];
  int       pos [N];
  bit       act [N];
  int       bub [N];
  bit       rand_chk;
  logic [N-1:0] acc;

  // reference model: owner of the checker port, drain countdown after '#', rr pointer
  int         m_owner = -1;
  int         m_drain = 0;
  int         m_ptr   = 0;
  int         m_len   = 0;
  int         m_src   = 0;
  int         m_gs    = 0;
  logic [7:0] m_chk   = 8'h00;
  bit         m_rv    = 1'b0;
  bit         m_abort = 1'b0;
  logic [1:0] m_fmt   = 2'b00;
  logic [3:0] m_err   = 4'b0000;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int find_sol();
    int i;
    for (int k = 0; k < N; k++) begin
      i = (m_ptr + k) % N;
      if (req_valid[i] && req_char[i*8 +: 8] == 8'h5E) return i;
    end
    return -1;
  endfunction

  function automatic logic [N-1:0] exp_ready();
    logic [N-1:0] r;
    int g;
    r = '0;
    if (reset || m_drain > 0) return r;
    if (m_owner >= 0) begin
      r[m_owner] = 1'b1;
      return r;
    end
    g = find_sol();
    for (int i = 0; i < N; i++)
      if (req_valid[i] && req_char[i*8 +: 8] != 8'h5E) r[i] = 1'b1;
    if (g >= 0) r[g] = 1'b1;
    return r;
  endfunction

  task automatic model_update();
    bit ab;
    logic [7:0] ch;
    int g;
    ab = 1'b0;
    if (reset) begin
      m_owner = -1; m_drain = 0; m_ptr = 0; m_len = 0; m_chk = 8'h00; m_rv = 1'b0;
      m_src = 0; m_abort = 1'b0; m_fmt = 2'b00; m_err = 4'b0000; m_gs = 0;
      return;
    end
    m_rv = 1'b0;
    if (m_drain == 2) begin
      m_chk = 8'h00; m_drain = 1;
    end else if (m_drain == 1) begin
      m_fmt = chk_format_type; m_err = chk_error_code; m_src = m_owner; m_abort = 1'b0;
      m_rv = 1'b1; m_ptr = (m_owner + 1) % N; m_owner = -1; m_drain = 0; m_chk = 8'h00;
    end else if (m_owner >= 0) begin
      ch = req_char[m_owner*8 +: 8];
      if (!req_valid[m_owner]) ab = 1'b1;
      else if (ch == 8'h23) begin m_chk = ch; m_drain = 2; end
      else if (m_len + 1 == ML) ab = 1'b1;
      else begin m_chk = ch; m_len = (ch == 8'h5E) ? 1 : m_len + 1; end
      if (ab) begin
        m_chk = 8'h00; m_rv = 1'b1; m_src = m_owner; m_abort = 1'b1; m_fmt = 2'b00;
        m_err = 4'b0000; m_ptr = (m_owner + 1) % N; m_owner = -1;
      end
    end else begin
      g = find_sol();
      if (g >= 0) begin m_owner = g; m_gs = g; m_len = 1; m_chk = 8'h5E; end
      else m_chk = 8'h00;
    end
  endtask

  task automatic drive();
    for (int i = 0; i < N; i++) begin
      if (act[i] && pos[i] < ln[i].len() && pos[i] != bub[i]) begin
        req_valid[i] = 1'b1;
        req_char[i*8 +: 8] = ln[i][pos[i]];
      end else begin
        act[i] = 1'b0;
        req_valid[i] = 1'b0;
        req_char[i*8 +: 8] = 8'h00;
      end
    end
    if (rand_chk) begin
      chk_format_type = 2'($urandom_range(0, 3));
      chk_error_code  = 4'($urandom_range(0, 15));
    end
  endtask

  // one clock: drive, compare at negedge, advance model, then let accepted sources move on
  task automatic step();
    drive();
    @(negedge clk);
    check("req_ready", req_ready, exp_ready());
    check("chk_char", chk_char, m_chk);
    check("res_valid", res_valid, m_rv);
    check("res_src", res_src, m_src);
    check("res_abort", res_abort, m_abort);
    check("res_format_type", res_format_type, m_fmt);
    check("res_error_code", res_error_code, m_err);
    check("busy", busy, m_owner >= 0);
    check("grant_src", grant_src, m_gs);
    acc = req_valid & req_ready;
    model_update();
    @(posedge clk);
    #1;
    for (int i = 0; i < N; i++) if (acc[i]) pos[i]++;
  endtask

  function automatic bit quiet();
    for (int i = 0; i < N; i++) if (act[i]) return 1'b0;
    return (m_owner < 0) && (m_drain == 0) && !m_rv;
  endfunction

  task automatic run_idle(input int maxc);
    int n;
    n = 0;
    while (!quiet() && n < maxc) begin
      step();
      n++;
    end
    check("idle_timeout", quiet(), 1);
    step();
  endtask

  task automatic load(input int i, input string s, input int b);
    ln[i] = s; pos[i] = 0; act[i] = 1'b1; bub[i] = b;
  endtask

  function automatic string rand_line();
    string s;
    logic [7:0] ch;
    int len;
    s = "^";
    len = $urandom_range(1, 70);
    for (int k = 0; k < len; k++) begin
      ch = ($urandom_range(0, 40) == 0) ? 8'h5E : 8'(8'h30 + $urandom_range(0, 42));
      s = $sformatf("%s%c", s, ch);
    end
    return {s, "#"};
  endfunction

  initial begin
    string s4;
    int mask;
    reset = 1'b1;
    req_char = '0; req_valid = '0; s_req_char = '0; s_req_valid = '0;
    chk_format_type = 2'b00; chk_error_code = 4'b0000; rand_chk = 1'b0;
    for (int i = 0; i < N; i++) begin ln[i] = ""; pos[i] = 0; act[i] = 1'b0; bub[i] = -1; end
    step(); step();
    reset = 1'b0;
    step();

    // single contiguous line, checker reports format 01 / no error
    chk_format_type = 2'b01; chk_error_code = 4'b0000;
    load(0, "^10@00003000: $1 <= 00000000#", -1);
    run_idle(100);
    check("t1_res_src", res_src, 0);
    check("t1_res_fmt", res_format_type, 1);
    check("t1_res_err", res_error_code, 0);
    check("t1_res_abort", res_abort, 0);

    // simultaneous '^' from src1/src2 after reset, then pointer lands on 3
    reset = 1'b1; step(); reset = 1'b0;
    load(1, "^A1#", -1);
    load(2, "^B2#", -1);
    run_idle(100);
    load(0, "^C#", -1);
    load(3, "^D#", -1);
    step(); step();
    check("t2_ptr_grant3", grant_src, 3);
    run_idle(100);

    // bubble mid-line aborts
    rand_chk = 1'b1;
    load(0, "^10@00003000#", 7);
    run_idle(100);
    check("t3_abort", res_abort, 1);
    check("t3_busy", busy, 0);

    // stray chars in IDLE are dropped
    load(2, "xy", -1);
    run_idle(20);

    // reset in the middle of a line
    load(1, "^10@00003000: $1 <= 00000000#", -1);
    repeat (6) step();
    reset = 1'b1;
    for (int i = 0; i < N; i++) act[i] = 1'b0;
    step();
    reset = 1'b0;
    repeat (10) step();
    check("t6_busy", busy, 0);

    // random rounds: several sources contend, random lengths, occasional bubbles
    for (int r = 0; r < 30; r++) begin
      mask = $urandom_range(1, 15);
      for (int i = 0; i < N; i++)
        if (mask[i]) load(i, rand_line(), ($urandom_range(0, 5) == 0) ? $urandom_range(1, 20) : -1);
      run_idle(600);
    end

    // overlength on the MAX_LEN=8 instance: 8th char accepted without '#' aborts
    s4 = "^1234567890";
    for (int i = 0; i <= ML_S; i++) begin
      s_req_char[31:24] = s4[i];
      s_req_valid = 4'b1000;
      @(negedge clk);
      check("t4_ready", s_req_ready, 4'b1000);
      check("t4_res_valid", s_res_valid, i == ML_S);
      check("t4_chk_char", s_chk_char, (i >= 1 && i <= ML_S - 1) ? s4[i-1] : 8'h00);
      if (i == ML_S) begin
        check("t4_res_src", s_res_src, 3);
        check("t4_res_abort", s_res_abort, 1);
      end
      @(posedge clk);
      #1;
    end
    s_req_valid = 4'b0000;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
